// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller.
//   - opcode constants OP_ADD..OP_CMP (1100-1111 reserved)
//   - condition-code constants COND_EQ..COND_NV
//   - NZCV flag bit indices
//   - controller FSM state enum
package alu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOVN = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_LSR  = 4'b1000;
  localparam logic [3:0] OP_LSL  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULW = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Opcodes 1100-1111 have no ALU function.
  function automatic logic is_reserved(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator (combinational).
//   cond  [3:0] : instruction condition code
//   flags [3:0] : current NZCV register
//   pass        : 1 when the instruction should execute
module cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller in front of the ALU. Accepts one instruction
// at a time, checks its condition against the NZCV register, drives the
// ALU inputs, waits MUL_LAT cycles for MUL, captures result and flags and
// offers the result on a writeback port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_*                  instruction input (valid/ready)
//   alu_reg1/2, alu_iv,
//   alu_opcode, alu_s,
//   alu_flag                 latched operands and current flags to the ALU
//   alu_result, alu_new_flag ALU outputs (combinational, external ALU)
//   wb_valid/ready, wb_rd,
//   wb_data                  writeback toward the register file
//   flags                    NZCV register
//   skipped, illegal         one-cycle pulses in the EXEC cycle
//   state_dbg                current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. Issue: ready is high only in IDLE (and low during reset);
// the source holds fields while valid is high. Writeback: wb_valid stays
// high with wb_rd/wb_data stable until wb_ready is seen.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter logic [3:0] MUL_LAT = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  issue_opcode,
  input  logic [3:0]  issue_cond,
  input  logic        issue_s,
  input  logic [3:0]  issue_rd,
  input  logic [31:0] issue_op1,
  input  logic [31:0] issue_op2,
  input  logic [15:0] issue_iv,
  output logic [31:0] alu_reg1,
  output logic [31:0] alu_reg2,
  output logic [15:0] alu_iv,
  output logic [3:0]  alu_opcode,
  output logic        alu_s,
  output logic [3:0]  alu_flag,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_new_flag,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [3:0]  flags,
  output logic        skipped,
  output logic        illegal,
  output logic [1:0]  state_dbg
);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [3:0] cond_q;
  logic       cond_pass;
  logic       accept, capture, load_cnt, dec_cnt;

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (flags),
    .pass  (cond_pass)
  );

  assign alu_flag  = flags;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    issue_ready = 1'b0;
    wb_valid    = 1'b0;
    skipped     = 1'b0;
    illegal     = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    load_cnt    = 1'b0;
    dec_cnt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issue_ready = ~rst;
        if (issue_valid && !rst) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Reserved opcodes are rejected regardless of their condition.
        if (is_reserved(alu_opcode)) begin
          illegal = 1'b1;
          state_d = ST_IDLE;
        end else if (!cond_pass) begin
          skipped = 1'b1;
          state_d = ST_IDLE;
        end else if (alu_opcode == OP_MUL && MUL_LAT > 4'd1) begin
          load_cnt = 1'b1;
          state_d  = ST_MULW;
        end else begin
          capture = 1'b1;
        end
      end
      ST_MULW: begin
        if (cnt_q == 4'd1) capture = 1'b1;
        else               dec_cnt = 1'b1;
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // CMP only updates flags; everything else goes on to writeback.
    if (capture) state_d = (alu_opcode == OP_CMP) ? ST_IDLE : ST_WB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_reg1   <= '0;
      alu_reg2   <= '0;
      alu_iv     <= '0;
      alu_opcode <= '0;
      alu_s      <= 1'b0;
      cond_q     <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      flags      <= '0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        alu_reg1   <= issue_op1;
        alu_reg2   <= issue_op2;
        alu_iv     <= issue_iv;
        alu_opcode <= issue_opcode;
        // CMP always needs its flags, so S is forced on for it.
        alu_s      <= issue_s | (issue_opcode == OP_CMP);
        cond_q     <= issue_cond;
        wb_rd      <= issue_rd;
      end
      if (load_cnt)     cnt_q <= MUL_LAT - 4'd1;
      else if (dec_cnt) cnt_q <= cnt_q - 4'd1;
      if (capture) begin
        if (alu_s) flags <= alu_new_flag;
        if (alu_opcode != OP_CMP) wb_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (MUL_LAT 4 and 1) share the issue
// stream; each has its own ALU model and a transaction-level reference.
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 900000");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus signals ----------------
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_opcode = '0, issue_cond = '0, issue_rd = '0;
  logic        issue_s = 1'b0;
  logic [31:0] issue_op1 = '0, issue_op2 = '0;
  logic [15:0] issue_iv = '0;
  logic        wb_ready = 1'b1;
  int          wb_mode = 0;   // 0 always ready, 1 random, 2 held low

  logic        rdy [2], as_o [2], wbv [2], skp [2], ill [2];
  logic [31:0] r1 [2], r2 [2], res [2], wbd [2];
  logic [15:0] ivo [2];
  logic [3:0]  opc [2], af [2], nf [2], wrd [2], flg [2];
  logic [1:0]  sdbg [2];

  int n_chk = 0;
  int n_fail = 0;

  // ---------------- ALU and condition models ----------------
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [15:0] iv,
                                         input logic [3:0] f);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    r = '0; c = f[1]; v = f[0];
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1, 4'd11: begin
        r = a - b; c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2:  r = a * b;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = a ^ b;
      4'd6:  r = ~b;
      4'd7:  r = b;
      4'd8:  r = a >> b[4:0];
      4'd9:  r = a << b[4:0];
      4'd10: r = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
      default: r = {16'hdead, iv};
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Odd condition codes are the complement of their even partner.
  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  assign {nf[0], res[0]} = alu_fn(opc[0], r1[0], r2[0], ivo[0], af[0]);
  assign {nf[1], res[1]} = alu_fn(opc[1], r1[1], r2[1], ivo[1], af[1]);

  // ---------------- DUTs ----------------
  alu_issue_ctrl #(.MUL_LAT(4'd4)) dut0 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy[0]),
    .issue_opcode(issue_opcode), .issue_cond(issue_cond), .issue_s(issue_s),
    .issue_rd(issue_rd), .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_iv(issue_iv),
    .alu_reg1(r1[0]), .alu_reg2(r2[0]), .alu_iv(ivo[0]), .alu_opcode(opc[0]),
    .alu_s(as_o[0]), .alu_flag(af[0]), .alu_result(res[0]), .alu_new_flag(nf[0]),
    .wb_valid(wbv[0]), .wb_ready(wb_ready), .wb_rd(wrd[0]), .wb_data(wbd[0]),
    .flags(flg[0]), .skipped(skp[0]), .illegal(ill[0]), .state_dbg(sdbg[0])
  );

  alu_issue_ctrl #(.MUL_LAT(4'd1)) dut1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(rdy[1]),
    .issue_opcode(issue_opcode), .issue_cond(issue_cond), .issue_s(issue_s),
    .issue_rd(issue_rd), .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_iv(issue_iv),
    .alu_reg1(r1[1]), .alu_reg2(r2[1]), .alu_iv(ivo[1]), .alu_opcode(opc[1]),
    .alu_s(as_o[1]), .alu_flag(af[1]), .alu_result(res[1]), .alu_new_flag(nf[1]),
    .wb_valid(wbv[1]), .wb_ready(wb_ready), .wb_rd(wrd[1]), .wb_data(wbd[1]),
    .flags(flg[1]), .skipped(skp[1]), .illegal(ill[1]), .state_dbg(sdbg[1])
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h, required %h", name, i, $time, act, exp);
    end
  endtask

  // Reference: one record per instance describing the instruction in flight.
  // out: 0 writeback, 1 compare, 2 skipped, 3 illegal. k counts cycles since accept.
  bit          m_busy [2];
  int          m_k [2], m_out [2], m_lat [2];
  logic [3:0]  m_flags [2], m_opc [2], m_rd [2];
  logic [31:0] m_r1 [2], m_r2 [2], m_wbd [2];
  logic [15:0] m_iv [2];
  logic        m_seff [2];
  logic [31:0] exp_q [$];   // writeback values still owed by dut0, oldest first
  int          mul_lat_of [2] = '{4, 1};

  task automatic model_reset(input int i);
    m_busy[i] = 0; m_k[i] = 0; m_out[i] = 0; m_lat[i] = 1;
    m_flags[i] = '0; m_opc[i] = '0; m_rd[i] = '0; m_r1[i] = '0; m_r2[i] = '0;
    m_wbd[i] = '0; m_iv[i] = '0; m_seff[i] = 1'b0;
    if (i == 0) exp_q.delete();
  endtask

  task automatic compare_and_step(input int i);
    logic [35:0] fr;
    if (rst) begin
      model_reset(i);
      chk("rst_issue_ready", i, 32'(rdy[i]), 32'd0);
      chk("rst_state", i, 32'(sdbg[i]), 32'(ST_IDLE));
    end else begin
      chk("issue_ready", i, 32'(rdy[i]), 32'(!m_busy[i]));
    end
    chk("wb_valid", i, 32'(wbv[i]), 32'(m_busy[i] && m_out[i] == 0 && m_k[i] > m_lat[i]));
    chk("skipped", i, 32'(skp[i]), 32'(m_busy[i] && m_k[i] == 1 && m_out[i] == 2));
    chk("illegal", i, 32'(ill[i]), 32'(m_busy[i] && m_k[i] == 1 && m_out[i] == 3));
    chk("flags", i, 32'(flg[i]), 32'(m_flags[i]));
    chk("alu_flag", i, 32'(af[i]), 32'(m_flags[i]));
    chk("alu_opcode", i, 32'(opc[i]), 32'(m_opc[i]));
    chk("alu_s", i, 32'(as_o[i]), 32'(m_seff[i]));
    chk("alu_reg1", i, r1[i], m_r1[i]);
    chk("alu_reg2", i, r2[i], m_r2[i]);
    chk("alu_iv", i, 32'(ivo[i]), 32'(m_iv[i]));
    chk("wb_rd", i, 32'(wrd[i]), 32'(m_rd[i]));
    chk("wb_data", i, wbd[i], m_wbd[i]);
    if (i == 0 && wbv[0] && wb_ready && exp_q.size() > 0) begin
      chk("wb_queue_data", 0, wbd[0], exp_q.pop_front());
    end
    if (rst) return;
    // advance to the next cycle
    if (m_busy[i]) begin
      if (m_out[i] >= 2) m_busy[i] = 0;
      else if (m_k[i] == m_lat[i]) begin
        fr = alu_fn(m_opc[i], m_r1[i], m_r2[i], m_iv[i], m_flags[i]);
        if (m_seff[i]) m_flags[i] = fr[35:32];
        if (m_out[i] == 1) m_busy[i] = 0;
        else begin
          m_wbd[i] = fr[31:0];
          if (i == 0) exp_q.push_back(fr[31:0]);
          m_k[i]++;
        end
      end else if (m_k[i] > m_lat[i]) begin
        if (wb_ready) m_busy[i] = 0;
      end else m_k[i]++;
    end else if (issue_valid) begin
      m_busy[i] = 1; m_k[i] = 1;
      m_opc[i] = issue_opcode; m_r1[i] = issue_op1; m_r2[i] = issue_op2;
      m_iv[i] = issue_iv; m_rd[i] = issue_rd;
      m_seff[i] = issue_s || (issue_opcode == 4'd11);
      m_lat[i] = (issue_opcode == 4'd2) ? mul_lat_of[i] : 1;
      if (issue_opcode >= 4'd12) m_out[i] = 3;
      else if (!cond_ok(issue_cond, m_flags[i])) m_out[i] = 2;
      else if (issue_opcode == 4'd11) m_out[i] = 1;
      else m_out[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    #3;
    for (int i = 0; i < 2; i++) compare_and_step(i);
  end

  always @(negedge clk) begin
    #1;
    case (wb_mode)
      0:       wb_ready = 1'b1;
      1:       wb_ready = 1'($urandom_range(0, 1));
      default: wb_ready = 1'b0;
    endcase
  end

  // ---------------- driver ----------------
  // Returns at the sampling point of cycle T+1 (T = accept cycle).
  task automatic issue(input logic [3:0] op, input logic [3:0] cc, input logic s,
                       input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] iv);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1]) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL issue_wait: issue_ready still low after %0d cycles, required high", waited);
      return;
    end
    #1;
    issue_valid = 1'b1; issue_opcode = op; issue_cond = cc; issue_s = s;
    issue_rd = rd; issue_op1 = a; issue_op2 = b; issue_iv = iv;
    @(negedge clk);
    #1 issue_valid = 1'b0;
    #2;
  endtask

  task automatic next_cycles(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0]  op;
    int          r;
    repeat (2) @(negedge clk);
    #3;
    chk("lit_reset_ready", 0, 32'(rdy[0]), 32'd0);
    chk("lit_reset_flags", 0, 32'(flg[0]), 32'd0);
    chk("lit_reset_wb_valid", 0, 32'(wbv[0]), 32'd0);
    @(negedge clk); #1 rst = 1'b0; #2;
    chk("lit_ready_after_reset", 0, 32'(rdy[0]), 32'd1);

    // ADD AL S=1 5+7 -> rd 3 data 12 at T+2, flags 0000
    issue(OP_ADD, COND_AL, 1'b1, 4'd3, 32'd5, 32'd7, 16'h0);
    chk("lit_add_exec_no_wb", 0, 32'(wbv[0]), 32'd0);
    next_cycles(1);
    chk("lit_add_wb_valid", 0, 32'(wbv[0]), 32'd1);
    chk("lit_add_wb_rd", 0, 32'(wrd[0]), 32'd3);
    chk("lit_add_wb_data", 0, wbd[0], 32'd12);
    chk("lit_add_flags", 0, 32'(flg[0]), 32'h0);

    // CMP 3,3 -> flags 0100, no writeback
    issue(OP_CMP, COND_AL, 1'b0, 4'd2, 32'd3, 32'd3, 16'h0);
    next_cycles(1);
    chk("lit_cmp_flags", 0, 32'(flg[0]), 32'b0100);
    chk("lit_cmp_no_wb", 0, 32'(wbv[0]), 32'd0);
    chk("lit_cmp_ready", 0, 32'(rdy[0]), 32'd1);

    // SUB EQ executes, SUB NE skipped
    issue(OP_SUB, COND_EQ, 1'b0, 4'd1, 32'd9, 32'd4, 16'h0);
    chk("lit_sub_eq_not_skipped", 0, 32'(skp[0]), 32'd0);
    next_cycles(1);
    chk("lit_sub_eq_wb_data", 0, wbd[0], 32'd5);
    issue(OP_SUB, COND_NE, 1'b1, 4'd1, 32'd9, 32'd4, 16'h0);
    chk("lit_sub_ne_skipped", 0, 32'(skp[0]), 32'd1);
    next_cycles(1);
    chk("lit_sub_ne_no_wb", 0, 32'(wbv[0]), 32'd0);
    chk("lit_sub_ne_flags", 0, 32'(flg[0]), 32'b0100);

    // MUL 6x7: dut0 (lat 4) wb at T+5, dut1 (lat 1) wb at T+2
    issue(OP_MUL, COND_AL, 1'b0, 4'd7, 32'd6, 32'd7, 16'h0);
    chk("lit_mul_ready_t1", 0, 32'(rdy[0]), 32'd0);
    next_cycles(1);
    chk("lit_mul1_wb_valid", 1, 32'(wbv[1]), 32'd1);
    chk("lit_mul1_wb_data", 1, wbd[1], 32'd42);
    chk("lit_mul4_not_yet", 0, 32'(wbv[0]), 32'd0);
    next_cycles(2);
    chk("lit_mul4_t4_ready", 0, 32'(rdy[0]), 32'd0);
    chk("lit_mul4_t4_no_wb", 0, 32'(wbv[0]), 32'd0);
    next_cycles(1);
    chk("lit_mul4_wb_valid", 0, 32'(wbv[0]), 32'd1);
    chk("lit_mul4_wb_data", 0, wbd[0], 32'd42);
    chk("lit_mul4_t5_ready", 0, 32'(rdy[0]), 32'd0);
    next_cycles(1);
    chk("lit_mul4_ready_again", 0, 32'(rdy[0]), 32'd1);

    // ADD with wb_ready low for three WB cycles
    wb_mode = 2;
    issue(OP_ADD, COND_AL, 1'b0, 4'd9, 32'd100, 32'd23, 16'h0);
    for (int c = 0; c < 3; c++) begin
      next_cycles(1);
      chk("lit_hold_wb_valid", 0, 32'(wbv[0]), 32'd1);
      chk("lit_hold_wb_data", 0, wbd[0], 32'd123);
      chk("lit_hold_ready", 0, 32'(rdy[0]), 32'd0);
    end
    wb_mode = 0;
    next_cycles(1);
    chk("lit_hold_handshake_valid", 0, 32'(wbv[0]), 32'd1);
    next_cycles(1);
    chk("lit_hold_after_valid", 0, 32'(wbv[0]), 32'd0);
    chk("lit_hold_after_ready", 0, 32'(rdy[0]), 32'd1);

    // reserved opcode, then NV condition
    issue(4'b1101, COND_AL, 1'b1, 4'd4, 32'd1, 32'd1, 16'h0);
    chk("lit_illegal_pulse", 0, 32'(ill[0]), 32'd1);
    next_cycles(1);
    chk("lit_illegal_flags", 0, 32'(flg[0]), 32'b0100);
    chk("lit_illegal_no_wb", 0, 32'(wbv[0]), 32'd0);
    issue(OP_ADD, COND_NV, 1'b1, 4'd4, 32'd1, 32'd1, 16'h0);
    chk("lit_nv_skipped", 0, 32'(skp[0]), 32'd1);

    // reset while dut0 is waiting on MUL
    issue(OP_MUL, COND_AL, 1'b1, 4'd6, 32'd3, 32'd5, 16'h0);
    @(negedge clk); #1 rst = 1'b1; #2;
    chk("lit_mulw_rst_wb_valid", 0, 32'(wbv[0]), 32'd0);
    chk("lit_mulw_rst_flags", 0, 32'(flg[0]), 32'd0);
    chk("lit_mulw_rst_alu_reg1", 0, r1[0], 32'd0);
    @(negedge clk); #1 rst = 1'b0; #2;
    chk("lit_post_rst_ready", 0, 32'(rdy[0]), 32'd1);
    issue(OP_ADD, COND_AL, 1'b0, 4'd5, 32'd1, 32'd2, 16'h0);
    next_cycles(1);
    chk("lit_post_rst_wb_data", 0, wbd[0], 32'd3);
    chk("lit_post_rst_wb_rd", 0, 32'(wrd[0]), 32'd5);

    // randomized traffic
    wb_mode = 1;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 19);
      if (r < 12)      op = 4'(r);
      else if (r < 17) op = OP_MUL;
      else             op = 4'(r - 5);
      issue(op, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom,
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        #2;
      end
    end
    wb_mode = 0;
    next_cycles(20);
    chk("drain_wb_queue_empty", 0, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
